// File: rtl/segre_main_memory.sv
// ---------------------------------------------------------------------------
// segre_main_memory
//
// Behavioural main-memory model placed directly below segre_mmu. It returns
// whole cache lanes after a fixed read latency and accepts byte, half and
// word write-through stores in a single cycle. Used by the core testbench and
// by FPGA builds as the backing store.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous reset, active-high (array contents are kept)
//   rd_req_i        lane read request, single-cycle pulse, honoured in IDLE
//   rd_addr_i       read byte address, lane offset bits ignored
//   wr_req_i        store request, committed on the same rising edge
//   wr_data_type_i  BYTE / HALF / WORD
//   wr_addr_i       store byte address (HALF/WORD aligned down)
//   wr_data_i       store data, right-justified, little-endian in memory
//   data_rdy_o      one-cycle pulse, RD_LATENCY cycles after rd_req_i
//   data_o          read lane, byte at lane base in [7:0]; held until next read
//   busy_o          high while a read is in flight
//   err_o           address error pulse (address checking builds only)
//
// Build option: define SEGRE_MM_ADDR_CHK_EN to flag addresses >= MEM_BYTES.
// Out-of-range stores are dropped, out-of-range reads return zero, and err_o
// pulses. Without it addresses wrap modulo MEM_BYTES and err_o stays 0.
// ---------------------------------------------------------------------------

typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
} memop_data_type_e;

module segre_main_memory #(
    parameter int ADDR_SIZE  = 32,
    parameter int LANE_SIZE  = 128,
    parameter int WORD_SIZE  = 32,
    parameter int MEM_BYTES  = 65536,
    parameter int RD_LATENCY = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rd_req_i,
    input  logic [ADDR_SIZE-1:0] rd_addr_i,
    input  logic                 wr_req_i,
    input  memop_data_type_e     wr_data_type_i,
    input  logic [ADDR_SIZE-1:0] wr_addr_i,
    input  logic [WORD_SIZE-1:0] wr_data_i,
    output logic                 data_rdy_o,
    output logic [LANE_SIZE-1:0] data_o,
    output logic                 busy_o,
    output logic                 err_o
);

    localparam int IDX_W      = $clog2(MEM_BYTES);
    localparam int LANE_BYTES = LANE_SIZE / 8;
    localparam int LANE_OFF   = $clog2(LANE_BYTES);
    localparam int WORD_BYTES = WORD_SIZE / 8;
    localparam int CNT_W      = (RD_LATENCY > 2) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    logic [7:0]       mem [MEM_BYTES];

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] rd_base_q;
    logic             rd_oor_q;

    logic             wr_oor;
    logic             rd_oor;
    logic             wr_en;
    logic [IDX_W-1:0] wr_base;
    logic [2:0]       wr_nbytes;
    logic             capture;
    logic [LANE_SIZE-1:0] lane_rd;

`ifdef SEGRE_MM_ADDR_CHK_EN
    assign wr_oor = |wr_addr_i[ADDR_SIZE-1:IDX_W];
    assign rd_oor = |rd_addr_i[ADDR_SIZE-1:IDX_W];
    logic unused_rd_lo;
    assign unused_rd_lo = ^rd_addr_i[LANE_OFF-1:0];
`else
    // Upper address bits are dropped so the array simply wraps.
    assign wr_oor = 1'b0;
    assign rd_oor = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{wr_addr_i[ADDR_SIZE-1:IDX_W],
                           rd_addr_i[ADDR_SIZE-1:IDX_W],
                           rd_addr_i[LANE_OFF-1:0]};
`endif

    assign wr_en   = wr_req_i && !wr_oor;
    assign capture = (state == WAIT) && (cnt == '0);

    // Store footprint: aligned base byte and number of bytes written.
    always_comb begin
        wr_base   = wr_addr_i[IDX_W-1:0];
        wr_nbytes = 3'd0;
        case (wr_data_type_i)
            BYTE: begin
                wr_base   = wr_addr_i[IDX_W-1:0];
                wr_nbytes = 3'd1;
            end
            HALF: begin
                wr_base   = {wr_addr_i[IDX_W-1:1], 1'b0};
                wr_nbytes = 3'd2;
            end
            WORD: begin
                wr_base   = {wr_addr_i[IDX_W-1:2], 2'b00};
                wr_nbytes = 3'(WORD_BYTES);
            end
            default: wr_nbytes = 3'd0;
        endcase
    end

    // Lane as it will look after this cycle's store: a store landing in the
    // lane during the capture cycle overrides the stale array bytes.
    always_comb begin
        lane_rd = '0;
        for (int i = 0; i < LANE_BYTES; i++) begin
            lane_rd[8*i +: 8] = mem[rd_base_q + IDX_W'(i)];
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (wr_en && (k < int'(wr_nbytes)) &&
                    (wr_base + IDX_W'(k) == rd_base_q + IDX_W'(i))) begin
                    lane_rd[8*i +: 8] = wr_data_i[8*k +: 8];
                end
            end
        end
    end

    // Array write port; not affected by reset or by the read FSM.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (k < int'(wr_nbytes)) begin
                    mem[wr_base + IDX_W'(k)] <= wr_data_i[8*k +: 8];
                end
            end
        end
    end

    // Read FSM with registered outputs. cnt is loaded with RD_LATENCY-2 so
    // that capture lands in cycle RD_LATENCY-1 and data_rdy_o in RD_LATENCY.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_base_q  <= '0;
            rd_oor_q   <= 1'b0;
            busy_o     <= 1'b0;
            data_rdy_o <= 1'b0;
            data_o     <= '0;
            err_o      <= 1'b0;
        end else begin
            data_rdy_o <= 1'b0;
            // A store error and a read error in the same cycle merge into one pulse.
            err_o      <= (wr_req_i && wr_oor) || (capture && rd_oor_q);
            case (state)
                IDLE: begin
                    if (rd_req_i) begin
                        rd_base_q <= {rd_addr_i[IDX_W-1:LANE_OFF], LANE_OFF'(0)};
                        rd_oor_q  <= rd_oor;
                        cnt       <= CNT_W'(RD_LATENCY - 2);
                        busy_o    <= 1'b1;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        data_o     <= rd_oor_q ? '0 : lane_rd;
                        data_rdy_o <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_segre_main_memory.sv
// ---------------------------------------------------------------------------
// tb_segre_main_memory
//
// Directed testbench for segre_main_memory: reset state, read latency and
// busy window, byte/half/word stores, capture-cycle store merge, ignored
// second read, reset during a read, and address range handling (both with
// and without SEGRE_MM_ADDR_CHK_EN).
// ---------------------------------------------------------------------------

module tb_segre_main_memory;

    localparam int RD_LATENCY = 10;
    localparam int MEM_BYTES  = 65536;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rd_req = 1'b0;
    logic [31:0]      rd_addr = '0;
    logic             wr_req = 1'b0;
    memop_data_type_e wr_type = BYTE;
    logic [31:0]      wr_addr = '0;
    logic [31:0]      wr_data = '0;
    logic             data_rdy;
    logic [127:0]     data;
    logic             busy;
    logic             err;

    int checks   = 0;
    int failures = 0;

    segre_main_memory #(
        .ADDR_SIZE (32),
        .LANE_SIZE (128),
        .WORD_SIZE (32),
        .MEM_BYTES (MEM_BYTES),
        .RD_LATENCY(RD_LATENCY)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rd_req_i      (rd_req),
        .rd_addr_i     (rd_addr),
        .wr_req_i      (wr_req),
        .wr_data_type_i(wr_type),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .data_rdy_o    (data_rdy),
        .data_o        (data),
        .busy_o        (busy),
        .err_o         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic store(input memop_data_type_e t, input logic [31:0] a,
                         input logic [31:0] d);
        wr_req  = 1'b1;
        wr_type = t;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_req  = 1'b0;
    endtask

    // Issues a read and checks busy/data_rdy on every cycle of the window.
    task automatic do_read(input string tag, input logic [31:0] a,
                           output logic [127:0] lane, output logic e);
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        rd_req  = 1'b0;
        lane    = '0;
        e       = 1'b0;
        for (int k = 1; k <= RD_LATENCY; k++) begin
            check_val({tag, "_busy"}, 128'(busy), 128'd1);
            check_val({tag, "_rdy"}, 128'(data_rdy),
                      (k == RD_LATENCY) ? 128'd1 : 128'd0);
            if (k == RD_LATENCY) begin
                lane = data;
                e    = err;
            end else begin
                tick();
            end
        end
        tick();
        check_val({tag, "_rdy_end"}, 128'(data_rdy), 128'd0);
        check_val({tag, "_busy_end"}, 128'(busy), 128'd0);
    endtask

    logic [127:0] lane;
    logic         e;
    int           pulses;

    initial begin
        // 1: reset then idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_val("rst_rdy", 128'(data_rdy), 128'd0);
        check_val("rst_busy", 128'(busy), 128'd0);
        check_val("rst_err", 128'(err), 128'd0);
        check_val("rst_data", data, 128'd0);

        // 2: word store, read from another address in the same lane
        store(WORD, 32'h100, 32'hDEADBEEF);
        tick();
        do_read("t2", 32'h104, lane, e);
        check_val("t2_word0", 128'(lane[31:0]), 128'hDEADBEEF);
        check_val("t2_err", 128'(e), 128'd0);

        // 3: byte/half/unaligned-word stores into a prefilled lane
        store(WORD, 32'h200, 32'h03020100);
        store(WORD, 32'h204, 32'h07060504);
        store(WORD, 32'h208, 32'h0B0A0908);
        store(WORD, 32'h20C, 32'h0F0E0D0C);
        store(BYTE, 32'h201, 32'hFFFFFFAA);
        store(HALF, 32'h207, 32'hFFFF1234);
        store(WORD, 32'h20B, 32'hCAFEBABE);
        do_read("t3", 32'h200, lane, e);
        check_val("t3_lane", lane, 128'h0F0E0D0C_CAFEBABE_12340504_0302AA00);

        // 4: ignored second request, store merged in the capture cycle
        store(WORD, 32'h300, 32'h30000000);
        store(WORD, 32'h304, 32'h30000004);
        store(WORD, 32'h308, 32'h30000008);
        store(WORD, 32'h30C, 32'hA0A0A0A0);
        rd_req  = 1'b1;
        rd_addr = 32'h300;
        tick();
        rd_req  = 1'b0;
        pulses  = 0;
        lane    = '0;
        for (int k = 1; k <= RD_LATENCY + 4; k++) begin
            if (data_rdy) pulses++;
            if (k == RD_LATENCY) lane = data;
            rd_req  = (k == 3);
            rd_addr = (k == 3) ? 32'h400 : 32'h300;
            wr_req  = (k == RD_LATENCY - 1);
            wr_type = WORD;
            wr_addr = 32'h30C;
            wr_data = 32'h00000055;
            tick();
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
        check_val("t4_pulses", 128'(pulses), 128'd1);
        check_val("t4_lane", lane, 128'h00000055_30000008_30000004_30000000);
        check_val("t4_busy_end", 128'(busy), 128'd0);

        // 5: reset mid-WAIT abandons the read; array survives
        rd_req  = 1'b1;
        rd_addr = 32'h100;
        tick();
        rd_req  = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t5_rdy", 128'(data_rdy), 128'd0);
        check_val("t5_busy", 128'(busy), 128'd0);
        check_val("t5_data", data, 128'd0);
        check_val("t5_err", 128'(err), 128'd0);
        pulses = 0;
        for (int k = 0; k < RD_LATENCY + 2; k++) begin
            if (data_rdy) pulses++;
            tick();
        end
        check_val("t5_no_pulse", 128'(pulses), 128'd0);
        do_read("t5r", 32'h100, lane, e);
        check_val("t5_word0", 128'(lane[31:0]), 128'hDEADBEEF);

        // 6: address range handling
        store(WORD, 32'h0, 32'h11111111);
        store(WORD, 32'h4, 32'h22222222);
        store(WORD, 32'h8, 32'h33333333);
        store(WORD, 32'hC, 32'h44444444);
        store(WORD, MEM_BYTES - 4, 32'h5A5A5A5A);
        check_val("t6_top_err", 128'(err), 128'd0);
        do_read("t6top", MEM_BYTES - 16, lane, e);
        check_val("t6_top_word", 128'(lane[127:96]), 128'h5A5A5A5A);
        store(WORD, MEM_BYTES + 4, 32'hCAFEF00D);
`ifdef SEGRE_MM_ADDR_CHK_EN
        check_val("t6_wr_err", 128'(err), 128'd1);
        tick();
        check_val("t6_wr_err_end", 128'(err), 128'd0);
        do_read("t6l0", 32'h0, lane, e);
        check_val("t6_lane0", lane, 128'h44444444_33333333_22222222_11111111);
        check_val("t6_lane0_err", 128'(e), 128'd0);
        do_read("t6oor", MEM_BYTES + 4, lane, e);
        check_val("t6_oor_data", lane, 128'd0);
        check_val("t6_oor_err", 128'(e), 128'd1);
`else
        check_val("t6_wr_err", 128'(err), 128'd0);
        do_read("t6wrap", MEM_BYTES + 4, lane, e);
        check_val("t6_wrap_lane", lane, 128'h44444444_33333333_CAFEF00D_11111111);
        check_val("t6_wrap_err", 128'(e), 128'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
